dcache_ctrl_nway: RTL
=====================

# dcache_ctrl_nway

Parametrised N-way set-associative data-cache controller FSM, successor to the two-way Dcache controller. Sits between the hit/valid/dirty outputs of the tag arrays and the per-way data/tag RAM write strobes, driving the CPU-side ready signals and the memory-side read/write handshakes. Adds a way count set by parameter, a victim index from an external replacement block, and a whole-cache flush: scan every set and way and write back each dirty line.

## Interface
- WAYS, 4, associativity; power of two, ≥2
- SET_BITS, 4, index width; cache has 2^SET_BITS sets
- WAY_BITS, $clog2(WAYS), way index width (derived)

- clk  in  1  clock, rising edge
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- r_valid, w_valid  in  1  CPU read/write request, held until the matching ready
- hit  in  WAYS  per-way tag match for the current index (at most one bit set)
- valid, dirty  in  WAYS  valid/dirty bits of the indexed set
- victim  in  WAY_BITS  replacement choice from the LRU block
- flush_req  in  1  level; request a full write-back flush
- dr_ready, dw_ready  in  1  memory read/write completion, 1-cycle pulse
- dr_valid, dw_valid  out  1  memory read/write request
- mem_we, tag_we  out  WAYS  one-hot data/tag RAM write enables
- valid_set, dirty_set, dirty_clr  out  1  update valid/dirty bits of the selected way
- sel_way  out  WAY_BITS  way addressed by the write-back mux and the bit updates
- lru_touch  out  1  mark sel_way most recently used
- data_from_mem  out  1  line-write mux: 1 = refill data, 0 = CPU-merged data
- r_ready, w_ready  out  1  CPU completion, 1-cycle pulse
- flush_active  out  1  index mux selects flush_set instead of the CPU address
- flush_set  out  SET_BITS  set index during a flush
- flush_done  out  1  1-cycle pulse at the end of a flush

## Operation
- All outputs are registered. Reset value of every output is 0. On reset the state is IDLE and the flush counters are 0.
- Tag arrays read combinationally, so hit, valid and dirty are valid in the same cycle the index is driven.
- States: IDLE, WRITE_BACK, FETCH, FINISH, FL_SCAN, FL_WB, FL_DONE.
- IDLE
  - flush_req has priority over CPU requests: go to FL_SCAN and set flush_active=1.
  - Otherwise, if r_valid or w_valid is set, branch on hit and victim state as below.
  - If both r_valid and w_valid are set, the request is treated as a write.
- Hit, go to FINISH. In the FINISH cycle:
  - sel_way = index of the hit bit, and lru_touch=1.
  - Read hit: r_ready=1.
  - Write hit: mem_we[sel_way]=1, dirty_set=1, data_from_mem=0, w_ready=1.
- Miss, sel_way = victim:
  - If valid[victim] and dirty[victim]: dw_valid=1, go to WRITE_BACK.
  - Otherwise: dr_valid=1, go to FETCH.
- WRITE_BACK: hold dw_valid. On dw_ready, drop dw_valid, raise dr_valid, go to FETCH.
- FETCH: hold dr_valid. On dr_ready, go to FINISH. In that FINISH cycle:
  - mem_we[sel_way]=1, tag_we[sel_way]=1, valid_set=1, data_from_mem=1, lru_touch=1.
  - Write miss: dirty_set=1 and w_ready=1. The line merge is done by the datapath.
  - Read miss: dirty_clr=1 and r_ready=1.
- FINISH: clear all strobes, return to IDLE. The CPU request is not resampled in FINISH.
- Flush (counters flush_set and sel_way):
  - FL_SCAN: if valid[sel_way] and dirty[sel_way], raise dw_valid and go to FL_WB. Otherwise advance.
  - FL_WB: on dw_ready, pulse dirty_clr for sel_way, then advance.
  - Advance: increment sel_way. When it wraps from WAYS-1 to 0, increment flush_set.
  - After set 2^SET_BITS-1, way WAYS-1, go to FL_DONE.
  - FL_DONE: flush_done=1 for one cycle, flush_active=0, return to IDLE.
  - flush_req is not sampled again until IDLE.
- Boundary conditions:
  - dr_ready or dw_ready outside its waiting state is ignored.
  - A multi-hot hit vector is illegal; the lowest index is used.
  - A request dropped before its ready is illegal.

## Timing
- Hit: request sampled at edge t; ready high during cycle t+1; IDLE again at t+2.
- Clean miss: dr_valid from t+1; ready one cycle after the edge that samples dr_ready.
- Dirty miss adds the write-back handshake ahead of the fetch. There is one dead cycle between dw_ready and dr_valid being sampled.
- Flush of a fully clean cache takes 2^SET_BITS·WAYS FL_SCAN cycles plus 1 for FL_DONE.
- Reset mid-operation aborts any memory transaction; the memory model must be reset together with the controller. The dirty bits of lines already flushed stay cleared.

## Structure
- dcache_pkg holds:
  - the state enum
  - the default WAYS and SET_BITS values
  - a clog2 helper
- One sub-module, dcache_way_enc: a priority encoder from a one-hot WAYS-bit vector to a WAY_BITS index plus an any-set flag, used for hit to sel_way.

## Test plan
- WAYS=4, hit=4'b0100, r_valid: r_ready pulses at t+1, sel_way=2, lru_touch=1, mem_we=0.
- w_valid, hit=4'b0001: mem_we=4'b0001, dirty_set=1, w_ready pulse, data_from_mem=0.
- Read miss, victim=3, valid=4'b1000, dirty=4'b1000:
  - dw_valid holds until dw_ready (delayed 5 cycles).
  - Then dr_valid, then dr_ready.
  - Then tag_we=mem_we=4'b1000, dirty_clr=1, r_ready pulse.
- Write miss, victim=1, clean: skips WRITE_BACK; FINISH has dirty_set=1, w_ready=1.
- Flush with SET_BITS=2, dirty lines only at (set 1, way 2) and (set 3, way 0):
  - exactly two dw_valid handshakes, with the matching flush_set and sel_way values;
  - flush_done after 16 scanned positions.
- Drop rstn while in FETCH: all outputs 0 immediately; state IDLE.
- Check flush priority: flush_req and r_valid asserted in the same cycle → flush runs first, then the read is served.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way data-cache controller: state encoding,
// default geometry and a constant log2 helper.
package dcache_pkg;

   localparam int unsigned DC_WAYS     = 4;
   localparam int unsigned DC_SET_BITS = 4;

   typedef logic [2:0] dc_state_t;

   localparam dc_state_t ST_IDLE       = 3'd0;
   localparam dc_state_t ST_WRITE_BACK = 3'd1;
   localparam dc_state_t ST_FETCH      = 3'd2;
   localparam dc_state_t ST_FINISH     = 3'd3;
   localparam dc_state_t ST_FL_SCAN    = 3'd4;
   localparam dc_state_t ST_FL_WB      = 3'd5;
   localparam dc_state_t ST_FL_DONE    = 3'd6;

   // Ceiling log2, usable in parameter expressions.
   function automatic int unsigned dc_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dcache_way_enc.sv
// Priority encoder from a way vector to a way index; the lowest set bit wins,
// so an illegal multi-hot hit still selects a single deterministic way.
module dcache_way_enc
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS     = DC_WAYS,
   parameter int unsigned WAY_BITS = dc_clog2(WAYS)
) (
   input  logic [WAYS-1:0]     i_vec,
   output logic [WAY_BITS-1:0] o_idx,
   output logic                o_any
);

   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = int'(WAYS) - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = WAY_BITS'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dcache_ctrl_nway.sv
// N-way set-associative data-cache controller: hit/miss handling with victim
// write-back and refill, plus a whole-cache write-back flush. All outputs registered.
module dcache_ctrl_nway
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS     = DC_WAYS,
   parameter int unsigned SET_BITS = DC_SET_BITS,
   parameter int unsigned WAY_BITS = dc_clog2(WAYS)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                r_valid,
   input  logic                w_valid,
   input  logic [WAYS-1:0]     hit,
   input  logic [WAYS-1:0]     valid,
   input  logic [WAYS-1:0]     dirty,
   input  logic [WAY_BITS-1:0] victim,
   input  logic                flush_req,
   input  logic                dr_ready,
   input  logic                dw_ready,
   output logic                dr_valid,
   output logic                dw_valid,
   output logic [WAYS-1:0]     mem_we,
   output logic [WAYS-1:0]     tag_we,
   output logic                valid_set,
   output logic                dirty_set,
   output logic                dirty_clr,
   output logic [WAY_BITS-1:0] sel_way,
   output logic                lru_touch,
   output logic                data_from_mem,
   output logic                r_ready,
   output logic                w_ready,
   output logic                flush_active,
   output logic [SET_BITS-1:0] flush_set,
   output logic                flush_done
);

   dc_state_t           r_state, w_state_d;
   logic [WAY_BITS-1:0] r_sel_way, w_sel_way_d;
   logic [SET_BITS-1:0] r_flush_set, w_flush_set_d;
   logic                r_is_write, w_is_write_d;
   logic                r_dr_valid, w_dr_valid_d;
   logic                r_dw_valid, w_dw_valid_d;
   logic [WAYS-1:0]     r_mem_we, w_mem_we_d;
   logic [WAYS-1:0]     r_tag_we, w_tag_we_d;
   logic                r_valid_set, w_valid_set_d;
   logic                r_dirty_set, w_dirty_set_d;
   logic                r_dirty_clr, w_dirty_clr_d;
   logic                r_lru_touch, w_lru_touch_d;
   logic                r_data_from_mem, w_data_from_mem_d;
   logic                r_r_ready, w_r_ready_d;
   logic                r_w_ready, w_w_ready_d;
   logic                r_flush_active, w_flush_active_d;
   logic                r_flush_done, w_flush_done_d;

   logic [WAY_BITS-1:0] w_hit_idx;
   logic                w_hit_any;
   logic [WAYS-1:0]     w_hit_oh;
   logic [WAYS-1:0]     w_cur_oh;
   logic                w_req;
   logic                w_victim_dirty;
   logic                w_scan_dirty;
   logic                w_last_way;
   logic                w_last_set;
   logic                w_advance;

   dcache_way_enc #(
      .WAYS     (WAYS),
      .WAY_BITS (WAY_BITS)
   ) u_hit_enc (
      .i_vec (hit),
      .o_idx (w_hit_idx),
      .o_any (w_hit_any)
   );

   assign w_hit_oh       = WAYS'(1) << w_hit_idx;
   assign w_cur_oh       = WAYS'(1) << r_sel_way;
   assign w_req          = r_valid | w_valid;
   assign w_victim_dirty = valid[victim] & dirty[victim];
   assign w_scan_dirty   = valid[r_sel_way] & dirty[r_sel_way];
   assign w_last_way     = (r_sel_way == WAY_BITS'(WAYS - 1));
   assign w_last_set     = &r_flush_set;

   always_comb begin
      w_state_d         = r_state;
      w_sel_way_d       = r_sel_way;
      w_flush_set_d     = r_flush_set;
      w_is_write_d      = r_is_write;
      w_dr_valid_d      = r_dr_valid;
      w_dw_valid_d      = r_dw_valid;
      w_flush_active_d  = r_flush_active;
      w_mem_we_d        = '0;
      w_tag_we_d        = '0;
      w_valid_set_d     = 1'b0;
      w_dirty_set_d     = 1'b0;
      w_dirty_clr_d     = 1'b0;
      w_lru_touch_d     = 1'b0;
      w_data_from_mem_d = 1'b0;
      w_r_ready_d       = 1'b0;
      w_w_ready_d       = 1'b0;
      w_flush_done_d    = 1'b0;
      w_advance         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (flush_req) begin
               w_state_d        = ST_FL_SCAN;
               w_flush_active_d = 1'b1;
               w_sel_way_d      = '0;
               w_flush_set_d    = '0;
            end else if (w_req) begin
               // A simultaneous read and write is served as a write.
               w_is_write_d = w_valid;
               if (w_hit_any) begin
                  w_state_d     = ST_FINISH;
                  w_sel_way_d   = w_hit_idx;
                  w_lru_touch_d = 1'b1;
                  if (w_valid) begin
                     w_mem_we_d    = w_hit_oh;
                     w_dirty_set_d = 1'b1;
                     w_w_ready_d   = 1'b1;
                  end else begin
                     w_r_ready_d = 1'b1;
                  end
               end else begin
                  w_sel_way_d = victim;
                  if (w_victim_dirty) begin
                     w_dw_valid_d = 1'b1;
                     w_state_d    = ST_WRITE_BACK;
                  end else begin
                     w_dr_valid_d = 1'b1;
                     w_state_d    = ST_FETCH;
                  end
               end
            end
         end
         ST_WRITE_BACK: begin
            if (dw_ready) begin
               w_dw_valid_d = 1'b0;
               w_dr_valid_d = 1'b1;
               w_state_d    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (dr_ready) begin
               w_dr_valid_d      = 1'b0;
               w_state_d         = ST_FINISH;
               w_mem_we_d        = w_cur_oh;
               w_tag_we_d        = w_cur_oh;
               w_valid_set_d     = 1'b1;
               w_data_from_mem_d = 1'b1;
               w_lru_touch_d     = 1'b1;
               if (r_is_write) begin
                  w_dirty_set_d = 1'b1;
                  w_w_ready_d   = 1'b1;
               end else begin
                  w_dirty_clr_d = 1'b1;
                  w_r_ready_d   = 1'b1;
               end
            end
         end
         ST_FINISH: begin
            w_state_d = ST_IDLE;
         end
         ST_FL_SCAN: begin
            if (w_scan_dirty) begin
               w_dw_valid_d = 1'b1;
               w_state_d    = ST_FL_WB;
            end else begin
               w_advance = 1'b1;
            end
         end
         ST_FL_WB: begin
            // Two phases: wait for dw_ready, then hold sel_way for the dirty_clr cycle.
            if (r_dirty_clr) begin
               w_advance = 1'b1;
            end else if (dw_ready) begin
               w_dw_valid_d  = 1'b0;
               w_dirty_clr_d = 1'b1;
            end
         end
         ST_FL_DONE: begin
            w_state_d = ST_IDLE;
         end
         default: begin
            w_state_d = ST_IDLE;
         end
      endcase

      if (w_advance) begin
         if (w_last_way) begin
            w_sel_way_d = '0;
            if (w_last_set) begin
               w_state_d        = ST_FL_DONE;
               w_flush_done_d   = 1'b1;
               w_flush_active_d = 1'b0;
            end else begin
               w_flush_set_d = r_flush_set + 1'b1;
               w_state_d     = ST_FL_SCAN;
            end
         end else begin
            w_sel_way_d = r_sel_way + 1'b1;
            w_state_d   = ST_FL_SCAN;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state         <= ST_IDLE;
         r_sel_way       <= '0;
         r_flush_set     <= '0;
         r_is_write      <= 1'b0;
         r_dr_valid      <= 1'b0;
         r_dw_valid      <= 1'b0;
         r_mem_we        <= '0;
         r_tag_we        <= '0;
         r_valid_set     <= 1'b0;
         r_dirty_set     <= 1'b0;
         r_dirty_clr     <= 1'b0;
         r_lru_touch     <= 1'b0;
         r_data_from_mem <= 1'b0;
         r_r_ready       <= 1'b0;
         r_w_ready       <= 1'b0;
         r_flush_active  <= 1'b0;
         r_flush_done    <= 1'b0;
      end else begin
         r_state         <= w_state_d;
         r_sel_way       <= w_sel_way_d;
         r_flush_set     <= w_flush_set_d;
         r_is_write      <= w_is_write_d;
         r_dr_valid      <= w_dr_valid_d;
         r_dw_valid      <= w_dw_valid_d;
         r_mem_we        <= w_mem_we_d;
         r_tag_we        <= w_tag_we_d;
         r_valid_set     <= w_valid_set_d;
         r_dirty_set     <= w_dirty_set_d;
         r_dirty_clr     <= w_dirty_clr_d;
         r_lru_touch     <= w_lru_touch_d;
         r_data_from_mem <= w_data_from_mem_d;
         r_r_ready       <= w_r_ready_d;
         r_w_ready       <= w_w_ready_d;
         r_flush_active  <= w_flush_active_d;
         r_flush_done    <= w_flush_done_d;
      end
   end

   assign dr_valid      = r_dr_valid;
   assign dw_valid      = r_dw_valid;
   assign mem_we        = r_mem_we;
   assign tag_we        = r_tag_we;
   assign valid_set     = r_valid_set;
   assign dirty_set     = r_dirty_set;
   assign dirty_clr     = r_dirty_clr;
   assign sel_way       = r_sel_way;
   assign lru_touch     = r_lru_touch;
   assign data_from_mem = r_data_from_mem;
   assign r_ready       = r_r_ready;
   assign w_ready       = r_w_ready;
   assign flush_active  = r_flush_active;
   assign flush_set     = r_flush_set;
   assign flush_done    = r_flush_done;

endmodule
